// File: rtl/myproc_core_param.sv
// myproc_core_param: parametrised 2-cycle-per-instruction processor core.
// Holds a byte-wide instruction memory that is filled through a valid/ready
// loader, four DATA_W-bit registers, Z/C flags and a handshaked output port.
// Instruction memory resets to 0xFF (HALT), so an unloaded core halts at once.
// Optional feature macro: MYPROC_MUL_EN enables the 11_10 MUL instruction.
// Without it that encoding is a NOP and no multiplier is built.
module myproc_core_param #(
  parameter int DATA_W     = 8,
  parameter int IMEM_DEPTH = 16,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  input  logic              run,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic              busy,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  // ALU result together with its carry/borrow bit.
  typedef struct packed {
    logic              c;
    logic [DATA_W-1:0] res;
  } alu_t;

  state_t            state;
  logic [ADDR_W-1:0] load_ptr;
  logic [7:0]        ir;
  logic [7:0]        imem [IMEM_DEPTH];
  logic [DATA_W-1:0] regs [4];
  logic              flag_z;
  logic              flag_c;

  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;
  alu_t              alu_out;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] br_tgt;
  logic [DATA_W-1:0] imm_val;
`ifdef MYPROC_MUL_EN
  alu_t              mul_out;
`endif

  // Two-operand ALU: ADD/SUB report carry/borrow in the extra top bit,
  // logic ops always clear it.
  function automatic alu_t alu_exec(input logic [1:0]        op,
                                    input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b);
    logic [DATA_W:0] wide;
    alu_t            r;
    case (op)
      2'b00:   wide = {1'b0, a} + {1'b0, b};
      2'b01:   wide = {1'b0, a} - {1'b0, b};
      2'b10:   wide = {1'b0, a & b};
      default: wide = {1'b0, a ^ b};
    endcase
    r.c   = wide[DATA_W];
    r.res = wide[DATA_W-1:0];
    return r;
  endfunction

`ifdef MYPROC_MUL_EN
  // Full-width product; C flags any significance lost in the truncation.
  function automatic alu_t mul_exec(input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] prod;
    alu_t                r;
    prod  = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    r.c   = |prod[2*DATA_W-1:DATA_W];
    r.res = prod[DATA_W-1:0];
    return r;
  endfunction
`endif

  // Decode operands and candidate results for the instruction held in IR.
  always_comb begin
    rd_val  = regs[ir[3:2]];
    rs_val  = regs[ir[1:0]];
    alu_out = alu_exec(ir[5:4], rd_val, rs_val);
    pc_inc  = pc + ADDR_W'(1);
    br_tgt  = ADDR_W'(ir[4:0]);
    imm_val = DATA_W'(ir[3:0]);
`ifdef MYPROC_MUL_EN
    mul_out = mul_exec(rd_val, rs_val);
`endif
  end

  // Control FSM, loader, register file, flags and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= '0;
      load_ptr   <= '0;
      ir         <= '0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      halted     <= 1'b0;
      busy       <= 1'b0;
      load_ready <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
      for (int i = 0; i < IMEM_DEPTH; i++) begin
        imem[i] <= 8'hFF;
      end
    end else begin
      // out_valid is a single-cycle pulse; only an OUT re-arms it.
      out_valid <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          if (load_en) begin
            state      <= S_LOAD;
            load_ptr   <= '0;
            load_ready <= 1'b1;
            halted     <= 1'b0;
          end else if (run) begin
            state  <= S_FETCH;
            pc     <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            halted <= 1'b0;
            busy   <= 1'b1;
            for (int i = 0; i < 4; i++) begin
              regs[i] <= '0;
            end
          end
        end

        S_LOAD: begin
          // Dropping load_en wins over a byte offered in the same cycle.
          if (!load_en) begin
            state      <= S_IDLE;
            load_ready <= 1'b0;
          end else if (load_valid) begin
            imem[load_ptr] <= load_data;
            load_ptr       <= load_ptr + ADDR_W'(1);
          end
        end

        S_FETCH: begin
          ir    <= imem[pc];
          state <= S_EXEC;
        end

        S_EXEC: begin
          state <= S_FETCH;
          pc    <= pc_inc;
          case (ir[7:6])
            2'b00: begin
              regs[ir[3:2]] <= alu_out.res;
              flag_z        <= (alu_out.res == '0);
              flag_c        <= alu_out.c;
            end
            2'b01: begin
              regs[ir[5:4]] <= imm_val;
            end
            2'b10: begin
              if (!ir[5] || flag_z) begin
                pc <= br_tgt;
              end
            end
            default: begin
              case (ir[5:4])
                2'b00: begin
                  out_data  <= rd_val;
                  out_valid <= 1'b1;
                end
                2'b01: begin
                  regs[ir[3:2]] <= in_data;
                end
                2'b10: begin
`ifdef MYPROC_MUL_EN
                  regs[ir[3:2]] <= mul_out.res;
                  flag_z        <= (mul_out.res == '0);
                  flag_c        <= mul_out.c;
`endif
                end
                default: begin
                  // HALT keeps pc on the HALT instruction itself.
                  state  <= S_HALT;
                  pc     <= pc;
                  halted <= 1'b1;
                  busy   <= 1'b0;
                end
              endcase
            end
          endcase
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_myproc_core_param.sv
// Directed bench for myproc_core_param (DATA_W=8, IMEM_DEPTH=16).
// Expected MUL result follows MYPROC_MUL_EN.
module tb_myproc_core_param;

  localparam int DATA_W     = 8;
  localparam int IMEM_DEPTH = 16;
  localparam int ADDR_W     = $clog2(IMEM_DEPTH);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_en;
  logic              load_valid;
  logic [7:0]        load_data;
  logic              load_ready;
  logic              run;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              halted;
  logic              busy;
  logic [ADDR_W-1:0] pc;

  int checks   = 0;
  int failures = 0;

  logic [7:0] prog_q[$];
  int         pulses;
  int         first_k;
  int         halt_k;
  logic [7:0] last_out;

  myproc_core_param #(.DATA_W(DATA_W), .IMEM_DEPTH(IMEM_DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .run        (run),
    .in_data    (in_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .halted     (halted),
    .busy       (busy),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog();
    load_en = 1'b1;
    tick();
    check("load_ready_hi", {31'b0, load_ready}, 32'd1);
    foreach (prog_q[i]) begin
      load_valid = 1'b1;
      load_data  = prog_q[i];
      tick();
    end
    load_valid = 1'b0;
    load_en    = 1'b0;
    tick();
    check("load_ready_lo", {31'b0, load_ready}, 32'd0);
  endtask

  task automatic run_prog(input int max_cyc);
    pulses  = 0;
    first_k = -1;
    halt_k  = -1;
    last_out = 8'h00;
    run = 1'b1;
    tick();
    run = 1'b0;
    check("busy_after_run", {31'b0, busy}, 32'd1);
    for (int k = 1; k <= max_cyc; k++) begin
      tick();
      if (out_valid) begin
        pulses++;
        last_out = out_data;
        if (first_k < 0) first_k = k;
      end
      if (halted) begin
        halt_k = k;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_data"},  32'(out_data), 32'd0);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_halted"},    {31'b0, halted}, 32'd0);
    check({tag, "_busy"},      {31'b0, busy}, 32'd0);
    check({tag, "_load_ready"},{31'b0, load_ready}, 32'd0);
    check({tag, "_pc"},        32'(pc), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    load_en    = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    run        = 1'b0;
    in_data    = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Program 1: LDI r0,5; LDI r1,3; ADD r0,r1; OUT r0; HALT
    prog_q = '{8'h45, 8'h53, 8'h01, 8'hC0, 8'hFF};
    load_prog();
    run_prog(100);
    check("p1_pulses",   32'(pulses), 32'd1);
    check("p1_out",      32'(last_out), 32'h08);
    check("p1_out_k",    32'(first_k), 32'd8);
    check("p1_halt_k",   32'(halt_k), 32'd10);
    check("p1_halted",   {31'b0, halted}, 32'd1);
    check("p1_pc",       32'(pc), 32'd4);
    check("p1_busy",     {31'b0, busy}, 32'd0);
    check("p1_held_out", 32'(out_data), 32'h08);

    // Program 2: 1 - 2 underflows to 0xFF with borrow
    prog_q = '{8'h41, 8'h52, 8'h11, 8'hC0, 8'hFF};
    load_prog();
    run_prog(100);
    check("p2_out",    32'(last_out), 32'hFF);
    check("p2_flag_c", {31'b0, dut.flag_c}, 32'd1);
    check("p2_flag_z", {31'b0, dut.flag_z}, 32'd0);
    check("p2_halted", {31'b0, halted}, 32'd1);

    // Program 3: count r0 down from 3 with BRZ/JMP loop, then OUT 0
    prog_q = '{8'h43, 8'h51, 8'h11, 8'hA5, 8'h82, 8'hC0, 8'hFF};
    load_prog();
    run_prog(200);
    check("p3_pulses", 32'(pulses), 32'd1);
    check("p3_out",    32'(last_out), 32'h00);
    check("p3_halted", {31'b0, halted}, 32'd1);
    check("p3_pc",     32'(pc), 32'd6);
    check("p3_flag_z", {31'b0, dut.flag_z}, 32'd1);

    // Loader wrap: 17 bytes, the 17th (HALT) overwrites address 0
    prog_q = {};
    for (int i = 0; i < IMEM_DEPTH; i++) prog_q.push_back(8'hC0);
    prog_q.push_back(8'hFF);
    load_prog();
    run_prog(20);
    check("wrap_halt_k", 32'(halt_k), 32'd2);
    check("wrap_pc",     32'(pc), 32'd0);
    check("wrap_pulses", 32'(pulses), 32'd0);

    // load_en has priority over run when leaving HALT
    load_en = 1'b1;
    run     = 1'b1;
    tick();
    check("prio_load_ready", {31'b0, load_ready}, 32'd1);
    check("prio_busy",       {31'b0, busy}, 32'd0);
    check("prio_halted",     {31'b0, halted}, 32'd0);
    load_en = 1'b0;
    run     = 1'b0;
    tick();

    // Reset asserted while OUT is in EXEC
    prog_q = '{8'h45, 8'h53, 8'h01, 8'hC0, 8'hFF};
    load_prog();
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (7) tick();
    check("mid_busy", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    tick();
    check("rst_no_pulse", {31'b0, out_valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    run_prog(20);
    check("post_rst_halt_k", 32'(halt_k), 32'd2);
    check("post_rst_pc",     32'(pc), 32'd0);
    check("post_rst_pulses", 32'(pulses), 32'd0);

    // MUL (or NOP when the feature is compiled out): r0=6, r1=7
    prog_q = '{8'h46, 8'h57, 8'hE1, 8'hC0, 8'hFF};
    load_prog();
    run_prog(100);
`ifdef MYPROC_MUL_EN
    check("mul_out", 32'(last_out), 32'h2A);
`else
    check("mul_out", 32'(last_out), 32'h06);
`endif
    check("mul_pc", 32'(pc), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
